// File: rtl/matrix_pkg.sv
// Shared constants, op_code/size encodings and the FSM state type for matrix_result_streamer.
package matrix_pkg;

  localparam int ELEM_W    = 8;
  localparam int DIM_MAX   = 5;
  localparam int DET_W     = 40;
  localparam int DET_BYTES = DET_W / ELEM_W;
  localparam int BUS_W     = DIM_MAX * DIM_MAX * ELEM_W;
  localparam int CNT_W     = 3;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_SCALE = 3'b010;
  localparam logic [2:0] OP_TRANS = 3'b011;
  localparam logic [2:0] OP_HADM  = 3'b100;
  localparam logic [2:0] OP_DET   = 3'b101;
  localparam logic [2:0] OP_MMUL  = 3'b110;

  localparam logic [1:0] SIZE_2X2 = 2'b00;
  localparam logic [1:0] SIZE_3X3 = 2'b01;
  localparam logic [1:0] SIZE_4X4 = 2'b10;
  localparam logic [1:0] SIZE_5X5 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TAG  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Highest row/column index for an encoded matrix size (N-1 = size+1).
  function automatic logic [CNT_W-1:0] dim_last(input logic [1:0] size);
    return CNT_W'({1'b0, size}) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/elem_addr_gen.sv
// Maps a (row, col) element position to its flat bit offset in the packed result bus.
module elem_addr_gen
  import matrix_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int DIM_MAX = 5,
  parameter int OFF_W   = 8
) (
  input  logic [CNT_W-1:0] row,
  input  logic [CNT_W-1:0] col,
  output logic [OFF_W-1:0] offset
);

  always_comb begin
    offset = OFF_W'(ELEM_W * (DIM_MAX * int'(row) + int'(col)));
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures one packed ALU result and streams it out a byte per beat over valid/ready.
// Optional overflow tag beat enabled by defining MATRIX_STREAM_OVF_TAG_EN.
//
// Handshake: out_valid/out_data/out_last are held stable while out_valid=1 and
// out_ready=0; a beat transfers on a rising edge where both are high; out_valid
// never drops until the beat it presents has transferred (or reset aborts).
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int DIM_MAX = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [2:0]                         op_code,
  input  logic [1:0]                         matrix_size,
  input  logic signed [DIM_MAX*DIM_MAX*ELEM_W-1:0] result_final,
  input  logic                               overflow,
  output logic [ELEM_W-1:0]                  out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output state_e                             dbg_state
);

  localparam int BW    = DIM_MAX * DIM_MAX * ELEM_W;
  localparam int OFF_W = $clog2(BW);

  state_e            state_q, state_d;
  logic [BW-1:0]     data_q, data_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        size_q, size_d;
  logic [CNT_W-1:0]  r_q, r_d;
  logic [CNT_W-1:0]  c_q, c_d;
`ifdef MATRIX_STREAM_OVF_TAG_EN
  logic              ovf_q, ovf_d;
`else
  logic              unused_ovf;
  assign unused_ovf = overflow;
`endif

  logic              is_det;
  logic [CNT_W-1:0]  n_last;
  logic              last_data;
  logic [OFF_W-1:0]  elem_off;
  logic [ELEM_W-1:0] elem_byte;

  // Determinant bytes reuse the same addressing with row fixed at 0.
  elem_addr_gen #(
    .ELEM_W  (ELEM_W),
    .DIM_MAX (DIM_MAX),
    .OFF_W   (OFF_W)
  ) u_addr (
    .row    (r_q),
    .col    (c_q),
    .offset (elem_off)
  );

  always_comb begin
    is_det    = (op_q == OP_DET);
    n_last    = dim_last(size_q);
    last_data = is_det ? (c_q == CNT_W'(DET_BYTES - 1))
                       : ((r_q == n_last) && (c_q == n_last));
    elem_byte = data_q[elem_off +: ELEM_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      op_q    <= '0;
      size_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
`ifdef MATRIX_STREAM_OVF_TAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      size_q  <= size_d;
      r_q     <= r_d;
      c_q     <= c_d;
`ifdef MATRIX_STREAM_OVF_TAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    size_d  = size_q;
    r_d     = r_q;
    c_d     = c_q;
`ifdef MATRIX_STREAM_OVF_TAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          data_d  = $unsigned(result_final);
          op_d    = op_code;
          size_d  = matrix_size;
          r_d     = '0;
          c_d     = '0;
`ifdef MATRIX_STREAM_OVF_TAG_EN
          ovf_d   = overflow;
`endif
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (last_data) begin
`ifdef MATRIX_STREAM_OVF_TAG_EN
            state_d = ST_TAG;
`else
            state_d = ST_DONE;
`endif
          end else if (!is_det && (c_q == n_last)) begin
            c_d = '0;
            r_d = r_q + CNT_W'(1);
          end else begin
            c_d = c_q + CNT_W'(1);
          end
        end
      end
`ifdef MATRIX_STREAM_OVF_TAG_EN
      ST_TAG: begin
        if (out_ready) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state_q;
    case (state_q)
      ST_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = elem_byte;
`ifndef MATRIX_STREAM_OVF_TAG_EN
        out_last  = last_data;
`endif
      end
`ifdef MATRIX_STREAM_OVF_TAG_EN
      ST_TAG: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = 1'b1;
        out_data  = {{(ELEM_W-1){1'b0}}, ovf_q};
      end
`endif
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Randomized self-checking bench for matrix_result_streamer against a frame-level byte model.
module tb_matrix_result_streamer;
  import matrix_pkg::*;

  localparam int BW = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op_code;
  logic [1:0]    matrix_size;
  logic signed [BW-1:0] result_final;
  logic          overflow;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  state_e        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  matrix_result_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_code      (op_code),
    .matrix_size  (matrix_size),
    .result_final (result_final),
    .overflow     (overflow),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected byte stream of one frame, straight from the element-order rules.
  task automatic build_expected(input logic [2:0] op, input logic [1:0] sz,
                                input logic [BW-1:0] d, input logic ovf);
    logic [7:0] tag_byte;
    int n;
    exp_q.delete();
    tag_byte = {7'b0, ovf};
    if (op == 3'b101) begin
      for (int i = 0; i < 5; i++) exp_q.push_back(d[8*i +: 8]);
    end else begin
      n = int'(sz) + 2;
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++)
          exp_q.push_back(d[8*(5*r + c) +: 8]);
    end
`ifdef MATRIX_STREAM_OVF_TAG_EN
    exp_q.push_back(tag_byte);
`endif
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] d;
    for (int i = 0; i < BW / 8; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_last"},  out_last, 0);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_data"},  out_data, 0);
  endtask

  // abort_after >= 0 pulses reset once that many beats have transferred.
  task automatic run_frame(input logic [2:0] op, input logic [1:0] sz, input logic [BW-1:0] d,
                           input logic ovf, input int mode, input int abort_after,
                           input bit mid_start);
    int cyc;
    int beats;
    bit have_prev;
    logic [7:0] prev_data;
    logic prev_last;
    logic [7:0] exp_b;
    build_expected(op, sz, d, ovf);

    @(negedge clk);
    op_code = op; matrix_size = sz; result_final = d; overflow = ovf;
    start = 1'b1; out_ready = 1'b0;
    check_eq("pre_valid", out_valid, 0);
    check_eq("pre_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    result_final = rand_bus(); op_code = 3'($urandom_range(0, 7));
    matrix_size = 2'($urandom_range(0, 3)); overflow = ~ovf;
    check_eq("lat_valid", out_valid, 1);
    check_eq("lat_busy", busy, 1);

    cyc = 0; beats = 0; have_prev = 0; prev_data = '0; prev_last = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      check_eq("frame_valid", out_valid, 1);
      check_eq("frame_busy", busy, 1);
      if (have_prev) begin
        check_eq("stall_data", out_data, prev_data);
        check_eq("stall_last", out_last, prev_last);
      end
      if (beats == abort_after) begin
        rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_abort");
        check_eq("post_abort_state", dbg_state, ST_IDLE);
        exp_q.delete();
        return;
      end
      out_ready = pick_ready(mode, cyc);
      if (mid_start && cyc == 1) begin
        start = 1'b1; result_final = rand_bus(); op_code = 3'b101; matrix_size = 2'b11;
      end else begin
        start = 1'b0;
      end
      if (out_ready) begin
        exp_b = exp_q.pop_front();
        check_eq($sformatf("beat%0d_data", beats), out_data, exp_b);
        check_eq($sformatf("beat%0d_last", beats), out_last, exp_q.size() == 0);
        beats++;
        have_prev = 0;
      end else begin
        have_prev = 1; prev_data = out_data; prev_last = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (exp_q.size() > 0) check_eq("frame_timeout", exp_q.size(), 0);

    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_valid", out_valid, 0);
    // start during DONE must be ignored
    start = 1'b1; result_final = rand_bus(); op_code = 3'b000; matrix_size = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_once", done, 0);
    check_eq("done_start_ignored", out_valid, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    logic [BW-1:0] d;
    rst = 1'b0; start = 1'b0; op_code = '0; matrix_size = '0;
    result_final = '0; overflow = 1'b0; out_ready = 1'b0;
    #23;
    check_idle_outputs("reset");
    check_eq("reset_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b1;

    // 2x2 add: elements 01,02 / 03,04 streamed back-to-back
    d = '0; d[7:0] = 8'h01; d[15:8] = 8'h02; d[47:40] = 8'h03; d[55:48] = 8'h04;
    run_frame(3'b000, 2'b00, d, 1'b0, 0, -1, 0);

    // 5x5 element k = k under alternating ready
    for (int k = 0; k < 25; k++) d[8*k +: 8] = 8'(k);
    run_frame(3'b110, 2'b11, d, 1'b0, 1, -1, 0);

    // determinant bytes, LSB first
    d = rand_bus(); d[39:0] = 40'h12_3456_789A;
    run_frame(3'b101, 2'b10, d, 1'b0, 0, -1, 0);

    // 3x3 aborted by reset after 4 beats, then a fresh 3x3 frame
    run_frame(3'b001, 2'b01, rand_bus(), 1'b0, 0, 4, 0);
    run_frame(3'b001, 2'b01, rand_bus(), 1'b0, 2, -1, 0);

    // overflow set, start pulsed mid-frame
    run_frame(3'b000, 2'b00, rand_bus(), 1'b1, 0, -1, 1);

    for (int t = 0; t < 25; t++) begin
      run_frame(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rand_bus(),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), -1,
                bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
